// File: rtl/cordic_ci_driver_if.sv
// Operand and result valid/ready streams between the host/DMA side and the cordic driver.
// The host drives through master; the driver receives through slave.
interface cordic_ci_driver_if #(
   parameter int DATA_W = 32
);
   logic              op_valid;
   logic              op_ready;
   logic [DATA_W-1:0] op_data;
   logic              res_valid;
   logic              res_ready;
   logic [DATA_W-1:0] res_data;

   modport master (
      output op_valid, op_data, res_ready,
      input  op_ready, res_valid, res_data
   );

   modport slave (
      input  op_valid, op_data, res_ready,
      output op_ready, res_valid, res_data
   );
endinterface

// File: rtl/cordic_ci_driver.sv
// Issues FP32 operands into the pipelined cordic unit and returns results in order through a
// credit-protected result FIFO. Optional handshake counters are enabled by CORDIC_DRV_STATS_EN.
//
//   state   | meaning
//   S_IDLE  | nothing in flight, accepting operands
//   S_BUSY  | work in flight or buffered, still accepting
//   S_FLUSH | not accepting, in-flight work completes and the FIFO drains
module cordic_ci_driver #(
   parameter int LATENCY    = 16,
   parameter int FIFO_DEPTH = 4,
   parameter int DATA_W     = 32
) (
   input  logic              clock,
   input  logic              reset_n,
   cordic_ci_driver_if.slave host,
   input  logic              flush,
   output logic              busy,
   output logic              ci_clk_en,
   output logic [DATA_W-1:0] ci_dataa,
   input  logic [DATA_W-1:0] ci_result
`ifdef CORDIC_DRV_STATS_EN
   ,
   output logic [31:0]       stat_issued,
   output logic [31:0]       stat_done
`endif
);

   localparam int              PTR_W   = $clog2(FIFO_DEPTH);
   localparam int              CNT_W   = $clog2(FIFO_DEPTH + 1);
   localparam logic [CNT_W:0]  DEPTH_C = (CNT_W + 1)'(FIFO_DEPTH);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_BUSY  = 2'd1;
   localparam logic [1:0] S_FLUSH = 2'd2;

   logic [1:0]         state, state_nxt;
   logic [LATENCY-1:0] valid_sr, valid_sr_nxt;
   logic [CNT_W-1:0]   inflight, inflight_nxt;
   logic [CNT_W-1:0]   fifo_count, fifo_count_nxt;
   logic [PTR_W-1:0]   wr_ptr, rd_ptr;
   logic [DATA_W-1:0]  fifo_mem [FIFO_DEPTH];
   logic [CNT_W:0]     used;
   logic               accepting, issue, capture, pop, busy_nxt;

   // Every operand holds a credit from issue until its result leaves the FIFO, so the
   // FIFO cannot overflow and the cordic pipeline never has to stall.
   assign used           = {1'b0, fifo_count} + {1'b0, inflight};
   assign accepting      = (state == S_IDLE) || (state == S_BUSY);
   assign host.op_ready  = reset_n && accepting && (used < DEPTH_C);
   assign issue          = host.op_valid && host.op_ready;
   assign ci_clk_en      = issue || (inflight != '0);
   assign capture        = valid_sr[LATENCY-1] && ci_clk_en;
   assign host.res_valid = (fifo_count != '0);
   assign host.res_data  = host.res_valid ? fifo_mem[rd_ptr] : '0;
   assign pop            = host.res_valid && host.res_ready;
   assign busy           = (inflight != '0) || (fifo_count != '0);

   always_comb begin
      valid_sr_nxt    = '0;
      valid_sr_nxt[0] = issue;
      for (int i = 1; i < LATENCY; i++) begin
         valid_sr_nxt[i] = valid_sr[i-1];
      end
   end

   always_comb begin
      inflight_nxt = inflight;
      if (issue && !capture) begin
         inflight_nxt = inflight + CNT_W'(1);
      end else if (!issue && capture) begin
         inflight_nxt = inflight - CNT_W'(1);
      end
      fifo_count_nxt = fifo_count;
      if (capture && !pop) begin
         fifo_count_nxt = fifo_count + CNT_W'(1);
      end else if (!capture && pop) begin
         fifo_count_nxt = fifo_count - CNT_W'(1);
      end
      busy_nxt = (inflight_nxt != '0) || (fifo_count_nxt != '0);
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (flush) begin
               state_nxt = S_FLUSH;
            end else if (issue) begin
               state_nxt = S_BUSY;
            end
         end
         S_BUSY: begin
            if (flush) begin
               state_nxt = S_FLUSH;
            end else if (!busy_nxt) begin
               state_nxt = S_IDLE;
            end
         end
         S_FLUSH: begin
            if (!busy && !flush) begin
               state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state      <= S_IDLE;
         valid_sr   <= '0;
         inflight   <= '0;
         fifo_count <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         ci_dataa   <= '0;
      end else begin
         state      <= state_nxt;
         inflight   <= inflight_nxt;
         fifo_count <= fifo_count_nxt;
         if (issue) begin
            ci_dataa <= host.op_data;
         end
         if (ci_clk_en) begin
            valid_sr <= valid_sr_nxt;
         end
         if (capture) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
      end
   end

   // Storage needs no reset: fifo_count gates every read of it.
   always_ff @(posedge clock) begin
      if (reset_n && capture) begin
         fifo_mem[wr_ptr] <= ci_result;
      end
   end

`ifdef CORDIC_DRV_STATS_EN
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         stat_issued <= '0;
         stat_done   <= '0;
      end else begin
         if (issue) begin
            stat_issued <= stat_issued + 32'd1;
         end
         if (pop) begin
            stat_done <= stat_done + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_cordic_ci_driver.sv
// Bench for cordic_ci_driver: a timestamped queue model of operands/results, checked every
// cycle, plus directed scenarios with literal expectations and a randomized phase.
`timescale 1ns/1ps
module tb_cordic_ci_driver;
   localparam int LATENCY    = 16;
   localparam int FIFO_DEPTH = 4;
   localparam int DATA_W     = 32;

   logic              clock = 1'b0;
   logic              reset_n;
   logic              flush;
   logic              busy;
   logic              ci_clk_en;
   logic [DATA_W-1:0] ci_dataa;
   logic [DATA_W-1:0] ci_result;
`ifdef CORDIC_DRV_STATS_EN
   logic [31:0]       stat_issued;
   logic [31:0]       stat_done;
`endif

   cordic_ci_driver_if #(.DATA_W(DATA_W)) bus ();

   always #5 clock = ~clock;

   cordic_ci_driver #(
      .LATENCY    (LATENCY),
      .FIFO_DEPTH (FIFO_DEPTH),
      .DATA_W     (DATA_W)
   ) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .host      (bus),
      .flush     (flush),
      .busy      (busy),
      .ci_clk_en (ci_clk_en),
      .ci_dataa  (ci_dataa),
      .ci_result (ci_result)
`ifdef CORDIC_DRV_STATS_EN
      ,
      .stat_issued (stat_issued),
      .stat_done   (stat_done)
`endif
   );

   // Cordic stub: an operand presented on dataa yields dataa+1 after LATENCY clk_en cycles,
   // counting the cycle it is presented in.
   logic [DATA_W-1:0] pipe [LATENCY-1];
   always @(posedge clock) begin
      if (ci_clk_en) begin
         pipe[0] <= ci_dataa;
         for (int i = 1; i < LATENCY - 1; i++) pipe[i] <= pipe[i-1];
      end
   end
   assign ci_result = pipe[LATENCY-2] + 32'd1;

   // Reference model: every accepted operand is one queue entry stamped with the cycle its
   // result becomes visible; the queue length is the credit consumption.
   typedef struct {
      logic [31:0] d;
      int          ready;
   } ent_t;

   ent_t        q[$];
   int          cyc = 0;
   bit          flushing = 1'b0;
   logic [31:0] last_dataa = '0;
   int unsigned n_issued = 0;
   int unsigned n_done = 0;
   int          checks = 0;
   int          errors = 0;
   bit          chk_en = 1'b0;
   int          seen_res = 0;
   bit          saw_stall = 1'b0;

   logic [31:0] ops2 [11] = '{32'h00000000, 32'h3DCCCCCD, 32'h3E4CCCCD, 32'h3E99999A,
                              32'h3ECCCCCD, 32'h3F000000, 32'h3F19999A, 32'h3F333333,
                              32'h3F4CCCCD, 32'h3F666666, 32'h3F800000};

   function automatic bit m_op_ready();
      return (reset_n === 1'b1) && !flushing && (q.size() < FIFO_DEPTH);
   endfunction

   function automatic bit m_res_valid();
      return (q.size() > 0) && (q[0].ready <= cyc);
   endfunction

   function automatic logic [31:0] m_res_data();
      return m_res_valid() ? q[0].d + 32'd1 : 32'd0;
   endfunction

   function automatic bit m_inflight();
      foreach (q[i]) if (q[i].ready > cyc) return 1'b1;
      return 1'b0;
   endfunction

   always @(posedge clock) begin
      bit iss, pop, was_busy;
      iss      = (bus.op_valid === 1'b1) && m_op_ready();
      pop      = m_res_valid() && (bus.res_ready === 1'b1);
      was_busy = (q.size() != 0);
      if (reset_n !== 1'b1) begin
         q.delete();
         flushing   = 1'b0;
         last_dataa = '0;
         n_issued   = 0;
         n_done     = 0;
      end else begin
         if (pop) begin
            void'(q.pop_front());
            n_done++;
         end
         if (iss) begin
            q.push_back('{d: bus.op_data, ready: cyc + LATENCY + 1});
            last_dataa = bus.op_data;
            n_issued++;
         end
         flushing = flushing ? (was_busy || flush) : flush;
      end
      cyc++;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
      end
   endtask

   always @(negedge clock) begin
      if (chk_en) begin
         check("op_ready",  bus.op_ready,  m_op_ready());
         check("res_valid", bus.res_valid, m_res_valid());
         check("res_data",  bus.res_data,  m_res_data());
         check("busy",      busy,          q.size() != 0);
         check("ci_clk_en", ci_clk_en,     ((bus.op_valid === 1'b1) && m_op_ready()) || m_inflight());
         check("ci_dataa",  ci_dataa,      last_dataa);
`ifdef CORDIC_DRV_STATS_EN
         check("stat_issued", stat_issued, n_issued);
         check("stat_done",   stat_done,   n_done);
`endif
      end
      if (reset_n === 1'b1 && bus.res_valid === 1'b1 && bus.res_ready === 1'b1) seen_res++;
      if (bus.op_valid === 1'b1 && bus.op_ready === 1'b0) saw_stall = 1'b1;
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic send(input logic [31:0] d, output int t_hs);
      bus.op_valid = 1'b1;
      bus.op_data  = d;
      t_hs = -1;
      for (int i = 0; i < 200 && t_hs < 0; i++) begin
         @(negedge clock);
         if (bus.op_ready === 1'b1) t_hs = cyc;
         tick();
      end
      bus.op_valid = 1'b0;
      checks++;
      if (t_hs < 0) begin
         errors++;
         $display("FAIL send_timeout: operand %h never accepted, expected a handshake", d);
      end
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      while (n < 400) begin
         @(negedge clock);
         if (busy === 1'b0) break;
         n++;
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL %s_timeout: busy=%b, expected 0 within 400 cycles", name, busy);
      end
      tick();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int t_hs, seen0, acc, n, bad;
      bit stall_ok;
`ifdef CORDIC_DRV_STATS_EN
      logic [31:0] s_iss0, s_done0;
`endif
      reset_n      = 1'b0;
      flush        = 1'b0;
      bus.op_valid = 1'b0;
      bus.op_data  = '0;
      bus.res_ready = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      check("rst_op_ready",  bus.op_ready,  0);
      check("rst_res_valid", bus.res_valid, 0);
      check("rst_busy",      busy,          0);
      check("rst_ci_clk_en", ci_clk_en,     0);
      check("rst_ci_dataa",  ci_dataa,      0);
      reset_n = 1'b1;
      chk_en  = 1'b1;

      // Single operand: result on the 17th cycle after the handshake.
      bus.res_ready = 1'b1;
      send(32'h3F800000, t_hs);
      n = 0;
      while (n < 40 && bus.res_valid !== 1'b1) begin
         @(negedge clock);
         n++;
      end
      check("single_latency", cyc - t_hs, LATENCY + 1);
      check("single_data",    bus.res_data, 32'h3F800001);
      wait_idle("single");

      // Streaming eleven operands; credits must throttle the source.
      seen0 = seen_res;
      saw_stall = 1'b0;
`ifdef CORDIC_DRV_STATS_EN
      s_iss0  = stat_issued;
      s_done0 = stat_done;
`endif
      foreach (ops2[i]) send(ops2[i], t_hs);
      wait_idle("stream");
      tick();
      check("stream_results", seen_res - seen0, 11);
      check("stream_stall",   saw_stall, 1);
      check("idle_clk_en",    ci_clk_en, 0);
`ifdef CORDIC_DRV_STATS_EN
      check("stat_issued_11", stat_issued - s_iss0, 11);
      check("stat_done_11",   stat_done - s_done0, 11);
`endif

      // Backpressure: only FIFO_DEPTH operands fit.
      bus.res_ready = 1'b0;
      acc = 0;
      for (int i = 0; i < 40; i++) begin
         bus.op_valid = (acc < 8);
         bus.op_data  = 32'h3F800000 + acc;
         @(negedge clock);
         if (bus.op_valid && bus.op_ready === 1'b1) acc++;
         tick();
      end
      bus.op_valid = 1'b0;
      check("bp_accepted", acc, 4);
      check("bp_op_ready", bus.op_ready, 0);
      @(negedge clock);
      check("bp_res_valid", bus.res_valid, 1);
      check("bp_res_data",  bus.res_data, 32'h3F800001);
      repeat (5) @(negedge clock);
      check("bp_res_hold",  bus.res_data, 32'h3F800001);
      tick();
      seen0 = seen_res;
      bus.res_ready = 1'b1;
      wait_idle("bp_drain");
      tick();
      check("bp_drained", seen_res - seen0, 4);

      // Flush with three operands in flight.
      seen0 = seen_res;
      send(32'h40000000, t_hs);
      send(32'h40400000, t_hs);
      send(32'h40800000, t_hs);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      stall_ok = 1'b1;
      n = 0;
      bus.op_valid = 1'b1;
      bus.op_data  = 32'h41000000;
      do begin
         @(negedge clock);
         if (busy === 1'b1 && bus.op_ready !== 1'b0) stall_ok = 1'b0;
         n++;
      end while (busy === 1'b1 && n < 400);
      bus.op_valid = 1'b0;
      check("flush_no_accept", stall_ok, 1);
      @(posedge clock);
      @(negedge clock);
      check("flush_reopen",    bus.op_ready, 1);
      check("flush_delivered", seen_res - seen0, 3);
      tick();

      // Flush while idle: closed for exactly one cycle.
      flush = 1'b1;
      tick();
      flush = 1'b0;
      @(negedge clock);
      check("idle_flush_closed", bus.op_ready, 0);
      @(negedge clock);
      check("idle_flush_open",   bus.op_ready, 1);
      tick();

      // Reset with three operands in flight discards everything.
      send(32'h3F000000, t_hs);
      send(32'h3F100000, t_hs);
      send(32'h3F200000, t_hs);
      tick();
      tick();
      reset_n = 1'b0;
      tick();
      check("mid_rst_op_ready",  bus.op_ready,  0);
      check("mid_rst_res_valid", bus.res_valid, 0);
      check("mid_rst_res_data",  bus.res_data,  0);
      check("mid_rst_busy",      busy,          0);
      check("mid_rst_ci_clk_en", ci_clk_en,     0);
      check("mid_rst_ci_dataa",  ci_dataa,      0);
      reset_n = 1'b1;
      bad = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clock);
         if (bus.res_valid !== 1'b0) bad++;
      end
      check("mid_rst_silent", bad, 0);
      tick();

      // Randomized traffic with occasional flushes and backpressure.
      for (int i = 0; i < 800; i++) begin
         bus.op_valid  = ($urandom_range(0, 99) < 60);
         bus.op_data   = $urandom;
         bus.res_ready = ($urandom_range(0, 99) < 50);
         flush         = ($urandom_range(0, 99) < 3);
         tick();
      end
      bus.op_valid  = 1'b0;
      flush         = 1'b0;
      bus.res_ready = 1'b1;
      wait_idle("random_drain");
      tick();
      check("final_clk_en", ci_clk_en, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
